dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Data-memory bus controller sitting directly downstream of the core's MEM stage. It accepts one load or store at a time on the core's `dreq`/`dwrite`/`daddr`/`dsize` port and answers with `dbusy`/`dready_n`. It drives a word-wide memory with a req/ack handshake, performing byte-lane steering, alignment checking and a bounded-wait timeout. The core's `ddata` inout is split into `dwdata`/`drdata` at the core top.

## Interface
- `TIMEOUT`, default 255: maximum number of ACCESS cycles without `mem_ack` before the access is aborted; legal range 1..255.
- `clk` in 1: single clock; everything is rising-edge.
- `rst` in 1: asynchronous, active-low reset.
- `dreq` in 1: core access request; sampled only in IDLE.
- `dwrite` in 1: 1 = store, 0 = load.
- `daddr` in 32: byte address.
- `dsize` in 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `dwdata` in 32: store data, right-justified.
- `drdata` out 32: load data, right-justified, zero-extended. The core performs sign extension.
- `dready_n` out 1: low for exactly one cycle when the access completes.
- `dbusy` out 1: high while the memory access is in flight.
- `derr` out 1: error flag; valid only while `dready_n` = 0.
- `mem_req` out 1: memory request, held until `mem_ack` arrives.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 30: word address, equal to `daddr[31:2]`.
- `mem_be` out 4: byte enables; bit i enables bits [8i+7:8i].
- `mem_wdata` out 32: lane-steered store data.
- `mem_rdata` in 32: memory read word; valid in the cycle `mem_ack` = 1.
- `mem_ack` in 1: single-cycle completion strobe from memory.

## Operation
- The FSM has three states: IDLE, ACCESS, RESP. The reset state is IDLE.
- IDLE:
  - `dbusy` = 0, `dready_n` = 1, `mem_req` = 0.
  - When `dreq` = 1, the block latches `daddr`, `dsize`, `dwrite` and `dwdata`.
  - If the request is misaligned, the next state is RESP with `derr` = 1 and no memory cycle. Misaligned means any of: `dsize` = 11; half with `daddr[0]` = 1; word with `daddr[1:0]` ≠ 0.
  - Otherwise the next state is ACCESS, and the wait counter is cleared to 0.
- ACCESS:
  - `mem_req` = 1 and `dbusy` = 1.
  - `mem_we`, `mem_addr`, `mem_be` and `mem_wdata` are held stable from the latched request.
  - On `mem_ack` = 1 the block captures read data and moves to RESP with `derr` = 0.
  - Otherwise the counter increments. When it reaches TIMEOUT−1 with no ack, the next state is RESP with `derr` = 1, and `drdata` is driven to 0.
- RESP:
  - `dready_n` = 0, `dbusy` = 0, `mem_req` = 0.
  - `drdata` and `derr` are valid.
  - The next state is always IDLE. `dreq` is ignored in this state.
- Lane steering, where `o` = `daddr[1:0]`:
  - Byte: `mem_be` = 1<<o; `mem_wdata` = `dwdata[7:0]` replicated ×4.
  - Half: `mem_be` = 0011 if `o[1]` = 0, else 1100; `mem_wdata` = `dwdata[15:0]` replicated ×2.
  - Word: `mem_be` = 1111; `mem_wdata` = `dwdata`.
- Load return:
  - `drdata` = (`mem_rdata` >> 8·o), masked to 8, 16 or 32 bits according to the size.
  - On a store, `drdata` holds its previous value.
- A `mem_ack` arriving while not in ACCESS is ignored.

## Timing
- Reset values: `drdata` = 0, `dready_n` = 1, `dbusy` = 0, `derr` = 0, `mem_req` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_be` = 0, `mem_wdata` = 0. Counter = 0, state = IDLE.
- All outputs are registered.
- Accepted request:
  - `dreq` sampled at edge N puts the block in ACCESS in cycle N+1, with `mem_req` high.
  - `mem_ack` in cycle N+k (k ≥ 1) gives `dready_n` low in cycle N+k+1.
  - Minimum latency is 2 cycles from `dreq` to `dready_n`.
- Misaligned request: `dready_n` is low in cycle N+1 with `derr` = 1. `mem_req` never rises.
- Timeout: `mem_req` stays high for exactly TIMEOUT cycles, then RESP.
- Back-to-back: the core drops `dreq` in the cycle it sees `dready_n` = 0. A new `dreq` in the following cycle (IDLE) is accepted. Peak throughput is one access per 3 cycles.
- `mem_ack` in the same cycle the timeout would fire: the ack wins, `derr` = 0.
- Reset asserted mid-access: all outputs return to reset values immediately (asynchronously). `mem_req` drops without waiting for ack, and the in-flight access is discarded.

## Test plan
- Word load at 0x100, `mem_ack` in the first ACCESS cycle, `mem_rdata` = 0xDEADBEEF → `mem_addr` = 0x40, `mem_be` = 1111; `dready_n` low 2 cycles after `dreq` with `drdata` = 0xDEADBEEF and `derr` = 0.
- Byte store at 0x203, `dwdata` = 0x000000A5, ack after 3 wait cycles → `mem_be` = 1000, `mem_wdata` = 0xA5A5A5A5, `mem_we` = 1; `dbusy` high 4 cycles; `dready_n` low 1 cycle.
- Half load at 0x102, `mem_rdata` = 0x8001_7FFF → `mem_be` = 1100, `drdata` = 0x00008001. Then byte load at 0x101 on the same data → `drdata` = 0x0000007F.
- Misaligned word load at 0x102, and separately `dsize` = 11 → `mem_req` stays 0; `dready_n` low in the next cycle with `derr` = 1.
- TIMEOUT = 4, no `mem_ack` → `mem_req` high for exactly 4 cycles, then `dready_n` low with `derr` = 1 and `drdata` = 0. A late `mem_ack` in IDLE has no effect.
- `rst` pulled low during ACCESS → `mem_req` and `dbusy` drop immediately. After release, a fresh word load completes normally.

Source files
------------

// File: rtl/dmem_ctrl_if.sv
// Bus interfaces for dmem_ctrl: core-side load/store port and word-wide
// memory port. Names follow the core/memory signal names.

interface dcore_if;
   logic        dreq;
   logic        dwrite;
   logic [31:0] daddr;
   logic [1:0]  dsize;
   logic [31:0] dwdata;
   logic [31:0] drdata;
   logic        dready_n;
   logic        dbusy;
   logic        derr;

   // Core drives requests, controller answers.
   modport master (output dreq, dwrite, daddr, dsize, dwdata,
                   input  drdata, dready_n, dbusy, derr);
   modport slave  (input  dreq, dwrite, daddr, dsize, dwdata,
                   output drdata, dready_n, dbusy, derr);
endinterface

interface dmem_if;
   logic        mem_req;
   logic        mem_we;
   logic [29:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   // Controller is the master of the memory handshake.
   modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                   input  mem_rdata, mem_ack);
   modport slave  (input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                   output mem_rdata, mem_ack);
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory bus controller: one load/store at a time, byte-lane steering,
// alignment check and bounded wait on the memory ack. All outputs registered.

module dmem_ctrl #(
   parameter int unsigned TIMEOUT = 255   // legal 1..255
) (
   input logic    clk,
   input logic    rst,          // asynchronous, active low
   dcore_if.slave core,
   dmem_if.master mem
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

   localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        err_d;
   logic        tout_d;

   logic [1:0]  size_q;
   logic [1:0]  off_q;
   logic        we_q;
   logic [29:0] addr_q;
   logic [3:0]  be_q;
   logic [31:0] wdata_q;
   logic [31:0] drdata_q;
   logic        dready_n_q;
   logic        dbusy_q;
   logic        derr_q;
   logic        mreq_q;

   logic        misalign;
   logic [3:0]  be_n;
   logic [31:0] wdata_n;
   logic [31:0] rd_shift;
   logic [31:0] rd_val;

   // Alignment check and lane steering from the live core request.
   always_comb begin
      misalign = 1'b0;
      be_n     = 4'b0000;
      wdata_n  = 32'h0;
      unique case (core.dsize)
         2'b00: begin
            be_n    = 4'b0001 << core.daddr[1:0];
            wdata_n = {4{core.dwdata[7:0]}};
         end
         2'b01: begin
            misalign = core.daddr[0];
            be_n     = core.daddr[1] ? 4'b1100 : 4'b0011;
            wdata_n  = {2{core.dwdata[15:0]}};
         end
         2'b10: begin
            misalign = (core.daddr[1:0] != 2'b00);
            be_n     = 4'b1111;
            wdata_n  = core.dwdata;
         end
         default: misalign = 1'b1;
      endcase
   end

   // Right-justify and zero-extend the returned word per latched size.
   always_comb begin
      rd_shift = mem.mem_rdata >> {off_q, 3'b000};
      unique case (size_q)
         2'b00:   rd_val = {24'h0, rd_shift[7:0]};
         2'b01:   rd_val = {16'h0, rd_shift[15:0]};
         default: rd_val = rd_shift;
      endcase
   end

   // FSM state and wait counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic; an ack on the final wait cycle beats the timeout.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      tout_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (core.dreq) begin
               if (misalign) begin
                  state_d = RESP;
                  err_d   = 1'b1;
               end else begin
                  state_d = ACCESS;
                  cnt_d   = 8'd0;
               end
            end
         end
         ACCESS: begin
            if (mem.mem_ack) begin
               state_d = RESP;
            end else if (cnt_q == CNT_MAX) begin
               state_d = RESP;
               err_d   = 1'b1;
               tout_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Registered outputs and the latched request.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         size_q     <= 2'b00;
         off_q      <= 2'b00;
         we_q       <= 1'b0;
         addr_q     <= 30'h0;
         be_q       <= 4'h0;
         wdata_q    <= 32'h0;
         drdata_q   <= 32'h0;
         dready_n_q <= 1'b1;
         dbusy_q    <= 1'b0;
         derr_q     <= 1'b0;
         mreq_q     <= 1'b0;
      end else begin
         mreq_q     <= (state_d == ACCESS);
         dbusy_q    <= (state_d == ACCESS);
         dready_n_q <= (state_d != RESP);
         if (state_d == RESP) derr_q <= err_d;
         if (state_q == IDLE && core.dreq) begin
            size_q  <= core.dsize;
            off_q   <= core.daddr[1:0];
            we_q    <= core.dwrite;
            addr_q  <= core.daddr[31:2];
            be_q    <= be_n;
            wdata_q <= wdata_n;
         end
         if (state_q == ACCESS && mem.mem_ack) begin
            if (!we_q) drdata_q <= rd_val;
         end else if (tout_d) begin
            drdata_q <= 32'h0;
         end
      end
   end

   assign core.drdata   = drdata_q;
   assign core.dready_n = dready_n_q;
   assign core.dbusy    = dbusy_q;
   assign core.derr     = derr_q;
   assign mem.mem_req   = mreq_q;
   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_be    = be_q;
   assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl (TIMEOUT = 4). A monitor pops expected
// responses from a queue whenever dready_n goes low; scenario tasks check
// the memory-side signals and timing inline.

module tb_dmem_ctrl;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } resp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   resp_t exp_q[$];
   logic [31:0] last_rd = 32'h0;

   dcore_if core_if();
   dmem_if  mem_if();

   dmem_ctrl #(.TIMEOUT(4)) dut (
      .clk  (clk),
      .rst  (rst),
      .core (core_if),
      .mem  (mem_if)
   );

   always #5 clk = ~clk;

   // Reference load-return model: lane select by part-select.
   function automatic logic [31:0] load_val(input logic [31:0] rd, input logic [1:0] o,
                                            input logic [1:0] s);
      logic [31:0] r;
      case (s)
         2'b00:   r = {24'h0, rd[8*o +: 8]};
         2'b01:   r = o[1] ? {16'h0, rd[31:16]} : {16'h0, rd[15:0]};
         default: r = rd;
      endcase
      return r;
   endfunction

   task automatic push_exp(input logic [31:0] d, input logic e);
      resp_t r;
      r.data = d;
      r.err  = e;
      exp_q.push_back(r);
      last_rd = d;
   endtask

   // Present a request for one sampling edge, then drop dreq.
   task automatic issue(input logic w, input logic [31:0] a, input logic [1:0] s,
                        input logic [31:0] d);
      core_if.dreq   = 1'b1;
      core_if.dwrite = w;
      core_if.daddr  = a;
      core_if.dsize  = s;
      core_if.dwdata = d;
      @(posedge clk); #1;
      core_if.dreq   = 1'b0;
   endtask

   // Scoreboard monitor: every completion is compared with the next expectation.
   always @(posedge clk) begin
      resp_t e;
      #1;
      if (rst === 1'b1 && core_if.dready_n === 1'b0) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL resp_unexpected drdata=%h derr=%b", core_if.drdata, core_if.derr);
         end else begin
            e = exp_q.pop_front();
            if (core_if.drdata !== e.data || core_if.derr !== e.err) begin
               n_fail++;
               $display("FAIL resp_data got drdata=%h derr=%b exp drdata=%h derr=%b",
                        core_if.drdata, core_if.derr, e.data, e.err);
            end
         end
      end
   end

   task automatic test_reset;
      logic [31:0] cnt;
      core_if.dreq = 1'b0; core_if.dwrite = 1'b0; core_if.daddr = '0;
      core_if.dsize = 2'b00; core_if.dwdata = '0;
      mem_if.mem_ack = 1'b0; mem_if.mem_rdata = '0;
      #2 rst = 1'b0;
      #20;
      n_checks++;
      if ({core_if.drdata, core_if.dready_n, core_if.dbusy, core_if.derr} !== {32'h0, 3'b100}) begin
         n_fail++;
         $display("FAIL reset_core got %h/%b%b%b exp 0/100", core_if.drdata,
                  core_if.dready_n, core_if.dbusy, core_if.derr);
      end
      n_checks++;
      if ({mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_be, mem_if.mem_wdata} !== 68'h0) begin
         n_fail++;
         $display("FAIL reset_mem got req=%b we=%b addr=%h be=%b wdata=%h exp all 0",
                  mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_be, mem_if.mem_wdata);
      end
      @(posedge clk); #3 rst = 1'b1;
      @(posedge clk); #1;
      cnt = 0;
      for (int c = 0; c < 3; c++) begin
         if (core_if.dbusy !== 1'b0 || mem_if.mem_req !== 1'b0) cnt++;
         @(posedge clk); #1;
      end
      n_checks++;
      if (cnt != 0) begin
         n_fail++;
         $display("FAIL reset_idle busy/req cycles got %0d exp 0", cnt);
      end
   endtask

   task automatic test_word_load;
      push_exp(load_val(32'hDEADBEEF, 2'b00, 2'b10), 1'b0);
      issue(1'b0, 32'h100, 2'b10, 32'h0);
      n_checks++;
      if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 30'h40 ||
          mem_if.mem_be !== 4'b1111 || mem_if.mem_we !== 1'b0) begin
         n_fail++;
         $display("FAIL word_load_bus got req=%b addr=%h be=%b we=%b exp 1/40/1111/0",
                  mem_if.mem_req, mem_if.mem_addr, mem_if.mem_be, mem_if.mem_we);
      end
      mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'hDEADBEEF;
      @(posedge clk); #1;
      mem_if.mem_ack = 1'b0;
      n_checks++;
      if (core_if.dready_n !== 1'b0 || mem_if.mem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL word_load_latency got dready_n=%b req=%b exp 0/0",
                  core_if.dready_n, mem_if.mem_req);
      end
      @(posedge clk); #1;
      n_checks++;
      if (core_if.dready_n !== 1'b1) begin
         n_fail++;
         $display("FAIL word_load_pulse got dready_n=%b exp 1", core_if.dready_n);
      end
   endtask

   // Ack lands on the fourth wait cycle, the same cycle the timeout would fire.
   task automatic test_byte_store;
      int busy;
      busy = 0;
      push_exp(last_rd, 1'b0);
      issue(1'b1, 32'h203, 2'b00, 32'h000000A5);
      n_checks++;
      if (mem_if.mem_be !== 4'b1000 || mem_if.mem_wdata !== 32'hA5A5A5A5 ||
          mem_if.mem_we !== 1'b1 || mem_if.mem_addr !== 30'h80) begin
         n_fail++;
         $display("FAIL byte_store_bus got be=%b wdata=%h we=%b addr=%h exp 1000/a5a5a5a5/1/80",
                  mem_if.mem_be, mem_if.mem_wdata, mem_if.mem_we, mem_if.mem_addr);
      end
      for (int c = 0; c < 4; c++) begin
         if (core_if.dbusy === 1'b1) busy++;
         if (c == 3) begin
            mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'h11223344;
         end
         @(posedge clk); #1;
      end
      mem_if.mem_ack = 1'b0;
      n_checks++;
      if (busy != 4 || core_if.dbusy !== 1'b0 || core_if.dready_n !== 1'b0) begin
         n_fail++;
         $display("FAIL byte_store_busy got busy=%0d dbusy=%b dready_n=%b exp 4/0/0",
                  busy, core_if.dbusy, core_if.dready_n);
      end
      @(posedge clk); #1;
      n_checks++;
      if (core_if.dready_n !== 1'b1) begin
         n_fail++;
         $display("FAIL byte_store_pulse got dready_n=%b exp 1", core_if.dready_n);
      end
   endtask

   task automatic test_half_byte_load;
      push_exp(load_val(32'h80017FFF, 2'b10, 2'b01), 1'b0);
      issue(1'b0, 32'h102, 2'b01, 32'h0);
      n_checks++;
      if (mem_if.mem_be !== 4'b1100) begin
         n_fail++;
         $display("FAIL half_load_be got %b exp 1100", mem_if.mem_be);
      end
      mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'h80017FFF;
      @(posedge clk); #1;
      mem_if.mem_ack = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (last_rd !== 32'h00008001) begin
         n_fail++;
         $display("FAIL half_model got %h exp 00008001", last_rd);
      end
      push_exp(load_val(32'h80017FFF, 2'b01, 2'b00), 1'b0);
      issue(1'b0, 32'h101, 2'b00, 32'h0);
      n_checks++;
      if (mem_if.mem_be !== 4'b0010) begin
         n_fail++;
         $display("FAIL byte_load_be got %b exp 0010", mem_if.mem_be);
      end
      mem_if.mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_if.mem_ack = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_misaligned;
      logic [31:0] addrs [2];
      logic [1:0]  sizes [2];
      addrs[0] = 32'h102; sizes[0] = 2'b10;
      addrs[1] = 32'h100; sizes[1] = 2'b11;
      for (int i = 0; i < 2; i++) begin
         push_exp(last_rd, 1'b1);
         issue(1'b0, addrs[i], sizes[i], 32'h0);
         n_checks++;
         if (mem_if.mem_req !== 1'b0 || core_if.dready_n !== 1'b0 || core_if.dbusy !== 1'b0) begin
            n_fail++;
            $display("FAIL misaligned_%0d got req=%b dready_n=%b dbusy=%b exp 0/0/0",
                     i, mem_if.mem_req, core_if.dready_n, core_if.dbusy);
         end
         @(posedge clk); #1;
         n_checks++;
         if (mem_if.mem_req !== 1'b0 || core_if.dready_n !== 1'b1) begin
            n_fail++;
            $display("FAIL misaligned_after_%0d got req=%b dready_n=%b exp 0/1",
                     i, mem_if.mem_req, core_if.dready_n);
         end
      end
   endtask

   // Two loads at peak rate: request, ACCESS, RESP, next request.
   task automatic test_back_to_back;
      int done;
      done = 0;
      for (int i = 0; i < 2; i++) begin
         push_exp(load_val(32'hCAFE0000 + i, 2'(i), 2'b00), 1'b0);
         issue(1'b0, 32'h300 + i, 2'b00, 32'h0);
         mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'hCAFE0000 + i;
         @(posedge clk); #1;
         mem_if.mem_ack = 1'b0;
         if (core_if.dready_n === 1'b0) done++;
         @(posedge clk); #1;
      end
      n_checks++;
      if (done != 2) begin
         n_fail++;
         $display("FAIL back_to_back completions got %0d exp 2", done);
      end
   endtask

   task automatic test_timeout;
      int  req_cyc;
      logic seen;
      req_cyc = 0;
      seen    = 1'b0;
      push_exp(32'h0, 1'b1);
      issue(1'b0, 32'h10, 2'b10, 32'h0);
      for (int c = 0; c < 10 && !seen; c++) begin
         if (core_if.dready_n === 1'b0) seen = 1'b1;
         else begin
            if (mem_if.mem_req === 1'b1) req_cyc++;
            @(posedge clk); #1;
         end
      end
      n_checks++;
      if (!seen || req_cyc != 4) begin
         n_fail++;
         $display("FAIL timeout got resp=%b req_cycles=%0d exp 1/4", seen, req_cyc);
      end
      @(posedge clk); #1;
      mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'hFFFFFFFF;
      @(posedge clk); #1;
      mem_if.mem_ack = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (mem_if.mem_req !== 1'b0 || core_if.dready_n !== 1'b1 ||
          core_if.dbusy !== 1'b0 || core_if.drdata !== 32'h0) begin
         n_fail++;
         $display("FAIL late_ack got req=%b dready_n=%b dbusy=%b drdata=%h exp 0/1/0/0",
                  mem_if.mem_req, core_if.dready_n, core_if.dbusy, core_if.drdata);
      end
   endtask

   task automatic test_reset_mid;
      issue(1'b0, 32'h20, 2'b10, 32'h0);
      n_checks++;
      if (mem_if.mem_req !== 1'b1 || core_if.dbusy !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_pre got req=%b dbusy=%b exp 1/1", mem_if.mem_req, core_if.dbusy);
      end
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if (mem_if.mem_req !== 1'b0 || core_if.dbusy !== 1'b0 ||
          mem_if.mem_addr !== 30'h0 || core_if.dready_n !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_async got req=%b dbusy=%b addr=%h dready_n=%b exp 0/0/0/1",
                  mem_if.mem_req, core_if.dbusy, mem_if.mem_addr, core_if.dready_n);
      end
      @(posedge clk); #3 rst = 1'b1;
      last_rd = 32'h0;
      @(posedge clk); #1;
      push_exp(load_val(32'h12345678, 2'b00, 2'b10), 1'b0);
      issue(1'b0, 32'h0, 2'b10, 32'h0);
      @(posedge clk); #1;
      mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'h12345678;
      @(posedge clk); #1;
      mem_if.mem_ack = 1'b0;
      n_checks++;
      if (core_if.dready_n !== 1'b0 || core_if.derr !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_after got dready_n=%b derr=%b exp 0/0",
                  core_if.dready_n, core_if.derr);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset;
      test_word_load;
      test_byte_store;
      test_half_byte_load;
      test_misaligned;
      test_back_to_back;
      test_timeout;
      test_reset_mid;
      repeat (3) @(posedge clk);
      #2;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain got %0d pending exp 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
